// File: rtl/sc_fac_sched.sv
// Scale-factor index scheduler for the CBFP exponent path: queues stage-0/stage-1 index vectors
// and emits one 32-lane sum per CBFP2 alert over a valid/ready handshake.
module sc_fac_sched #(
    parameter int FACTOR_WIDTH = 5,
    parameter int DATA_OUT     = 32,
    parameter int DEPTH        = 4
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  cbfp0_valid,
    input  logic [FACTOR_WIDTH*DATA_OUT-1:0]      sc_fac_cbfp0,
    input  logic                                  cbfp1_valid,
    input  logic [FACTOR_WIDTH*DATA_OUT-1:0]      sc_fac_cbfp1,
    input  logic                                  alert_cbfp2,
    input  logic                                  final_ready,
    output logic                                  final_valid,
    output logic [(FACTOR_WIDTH+1)*DATA_OUT-1:0]  final_sc_fac,
    output logic [7:0]                            blk_cnt,
    output logic                                  err_ovf,
    output logic                                  err_unf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = FACTOR_WIDTH;
    localparam int LW = FACTOR_WIDTH + 1;
    localparam int IW = FACTOR_WIDTH * DATA_OUT;
    localparam int OW = LW * DATA_OUT;

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t                 state_reg, state_next;
    logic                   clear_out;
    logic [1:0]             push_req;
    logic [1:0]             push_ok;
    logic [1:0]             drop;
    logic [1:0]             empty;
    logic [1:0][IW-1:0]     push_data;
    logic [1:0][IW-1:0]     head;
    logic [OW-1:0]          sum;
    logic [OW-1:0]          out_reg;
    logic [CW-1:0]          pend_reg;
    logic [7:0]             blk_cnt_reg;
    logic [2:0]             starve_cnt_reg;
    logic                   err_ovf_reg, err_unf_reg;
    logic                   slot_free, fire, xfer;
    logic                   alert_ok, alert_drop, starve;

    assign push_req  = {cbfp1_valid, cbfp0_valid};
    assign push_data = {sc_fac_cbfp1, sc_fac_cbfp0};

    assign slot_free  = (state_reg == S_EMPTY) | final_ready;
    assign fire       = (pend_reg != '0) & ~empty[0] & ~empty[1] & slot_free;
    assign xfer       = (state_reg == S_FULL) & final_ready;
    assign alert_ok   = alert_cbfp2 & ((pend_reg != CW'(DEPTH)) | fire);
    assign alert_drop = alert_cbfp2 & (pend_reg == CW'(DEPTH)) & ~fire;
    assign starve     = (pend_reg != '0) & (empty[0] | empty[1]);

    genvar gi;

    // Both stage FIFOs pop together on fire, so they share the pop strobe.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [IW-1:0] mem_reg [DEPTH];
            logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
            logic [CW-1:0] cnt_reg;
            logic          full;

            assign full        = (cnt_reg == CW'(DEPTH));
            assign empty[gi]   = (cnt_reg == '0);
            assign push_ok[gi] = push_req[gi] & (~full | fire);
            assign drop[gi]    = push_req[gi] & full & ~fire;
            assign head[gi]    = mem_reg[rd_ptr_reg];

            always_ff @(posedge clk) begin
                if (push_ok[gi]) begin
                    mem_reg[wr_ptr_reg] <= push_data[gi];
                end
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    cnt_reg    <= '0;
                end else begin
                    if (push_ok[gi]) wr_ptr_reg <= wr_ptr_reg + AW'(1);
                    if (fire)        rd_ptr_reg <= rd_ptr_reg + AW'(1);
                    case ({push_ok[gi], fire})
                        2'b10:   cnt_reg <= cnt_reg + CW'(1);
                        2'b01:   cnt_reg <= cnt_reg - CW'(1);
                        default: cnt_reg <= cnt_reg;
                    endcase
                end
            end
        end

        for (gi = 0; gi < DATA_OUT; gi++) begin : g_lane
            assign sum[gi*LW +: LW] = {1'b0, head[0][gi*FW +: FW]} + {1'b0, head[1][gi*FW +: FW]};
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        clear_out  = 1'b0;
        case (state_reg)
            S_EMPTY: begin
                if (fire) state_next = S_FULL;
            end
            S_FULL: begin
                if (!fire && final_ready) begin
                    state_next = S_EMPTY;
                    clear_out  = 1'b1;
                end
            end
            default: state_next = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg      <= S_EMPTY;
            out_reg        <= '0;
            pend_reg       <= '0;
            blk_cnt_reg    <= '0;
            starve_cnt_reg <= '0;
            err_ovf_reg    <= 1'b0;
            err_unf_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (fire)           out_reg <= sum;
            else if (clear_out) out_reg <= '0;

            case ({alert_ok, fire})
                2'b10:   pend_reg <= pend_reg + CW'(1);
                2'b01:   pend_reg <= pend_reg - CW'(1);
                default: pend_reg <= pend_reg;
            endcase

            if (xfer) blk_cnt_reg <= blk_cnt_reg + 8'd1;

            // Counter holds the number of prior starved cycles; saturates at 7.
            if (starve) begin
                if (starve_cnt_reg != 3'd7) starve_cnt_reg <= starve_cnt_reg + 3'd1;
                if (starve_cnt_reg > 3'(DEPTH)) err_unf_reg <= 1'b1;
            end else begin
                starve_cnt_reg <= '0;
            end

            if ((|drop) | alert_drop) err_ovf_reg <= 1'b1;
        end
    end

    assign final_valid  = (state_reg == S_FULL);
    assign final_sc_fac = out_reg;
    assign blk_cnt      = blk_cnt_reg;
    assign err_ovf      = err_ovf_reg;
    assign err_unf      = err_unf_reg;

endmodule

// File: tb/tb_sc_fac_sched.sv
// Bench for sc_fac_sched: directed scenarios plus randomized traffic against a queue-based model.
module tb_sc_fac_sched;

    localparam int FW    = 5;
    localparam int LANES = 32;
    localparam int DEPTH = 4;
    localparam int IW    = FW * LANES;
    localparam int LW    = FW + 1;
    localparam int OW    = LW * LANES;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cbfp0_valid, cbfp1_valid, alert_cbfp2, final_ready;
    logic [IW-1:0] sc_fac_cbfp0, sc_fac_cbfp1;
    logic          final_valid, err_ovf, err_unf;
    logic [OW-1:0] final_sc_fac;
    logic [7:0]    blk_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [IW-1:0] m_q0[$];
    logic [IW-1:0] m_q1[$];
    int            m_pend, m_blk, m_starve;
    bit            m_valid, m_ovf, m_unf;
    logic [OW-1:0] m_out;

    always #5 clk = ~clk;

    sc_fac_sched #(.FACTOR_WIDTH(FW), .DATA_OUT(LANES), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .cbfp0_valid(cbfp0_valid), .sc_fac_cbfp0(sc_fac_cbfp0),
        .cbfp1_valid(cbfp1_valid), .sc_fac_cbfp1(sc_fac_cbfp1),
        .alert_cbfp2(alert_cbfp2), .final_ready(final_ready),
        .final_valid(final_valid), .final_sc_fac(final_sc_fac),
        .blk_cnt(blk_cnt), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    function automatic logic [IW-1:0] fill_in(int v);
        logic [IW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*FW +: FW] = FW'(v);
        return r;
    endfunction

    function automatic logic [OW-1:0] fill_out(int v);
        logic [OW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*LW +: LW] = LW'(v);
        return r;
    endfunction

    function automatic logic [IW-1:0] rand_vec();
        logic [IW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*FW +: FW] = FW'($urandom_range(0, 31));
        return r;
    endfunction

    function automatic logic [OW-1:0] lane_sum(logic [IW-1:0] a, logic [IW-1:0] b);
        logic [OW-1:0] r;
        int s;
        for (int i = 0; i < LANES; i++) begin
            s = int'(a[i*FW +: FW]) + int'(b[i*FW +: FW]);
            r[i*LW +: LW] = LW'(s);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_q0.delete();
        m_q1.delete();
        m_pend = 0; m_blk = 0; m_starve = 0;
        m_valid = 0; m_ovf = 0; m_unf = 0;
        m_out = '0;
    endtask

    // Advance the model by one clock using the inputs currently driven, then step the DUT.
    task automatic tick();
        bit fire, xfer, starved;
        logic [IW-1:0] h0, h1;
        if (!rstn) begin
            model_reset();
        end else begin
            fire    = (m_pend > 0) && (m_q0.size() > 0) && (m_q1.size() > 0) && (!m_valid || final_ready);
            xfer    = m_valid && final_ready;
            starved = (m_pend > 0) && (m_q0.size() == 0 || m_q1.size() == 0);
            if (starved) begin
                if (m_starve > DEPTH) m_unf = 1;
                if (m_starve < 7) m_starve++;
            end else begin
                m_starve = 0;
            end
            if (xfer) m_blk = (m_blk + 1) % 256;
            if (fire) begin
                h0 = m_q0.pop_front();
                h1 = m_q1.pop_front();
                m_out   = lane_sum(h0, h1);
                m_valid = 1;
                m_pend--;
            end else if (xfer) begin
                m_out   = '0;
                m_valid = 0;
            end
            if (cbfp0_valid) begin
                if (m_q0.size() < DEPTH) m_q0.push_back(sc_fac_cbfp0); else m_ovf = 1;
            end
            if (cbfp1_valid) begin
                if (m_q1.size() < DEPTH) m_q1.push_back(sc_fac_cbfp1); else m_ovf = 1;
            end
            if (alert_cbfp2) begin
                if (m_pend < DEPTH) m_pend++; else m_ovf = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cbfp0_valid = 0; cbfp1_valid = 0; alert_cbfp2 = 0;
        sc_fac_cbfp0 = '0; sc_fac_cbfp1 = '0;
    endtask

    task automatic apply_reset();
        rstn = 0;
        idle_inputs();
        final_ready = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 5;
        if (final_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", final_valid); end
        if (final_sc_fac !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", final_sc_fac); end
        if (blk_cnt !== 8'd0) begin errors++; $display("FAIL reset_blk: got %0d expected 0", blk_cnt); end
        if (err_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", err_ovf); end
        if (err_unf !== 1'b0) begin errors++; $display("FAIL reset_unf: got %b expected 0", err_unf); end
        $display("test_reset: done");
    endtask

    task automatic test_single();
        apply_reset();
        cbfp0_valid = 1; sc_fac_cbfp0 = fill_in(3); tick();
        idle_inputs(); cbfp1_valid = 1; sc_fac_cbfp1 = fill_in(4); tick();
        idle_inputs(); alert_cbfp2 = 1; tick();
        idle_inputs(); tick();
        checks += 2;
        if (final_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", final_valid); end
        if (final_sc_fac !== fill_out(7)) begin errors++; $display("FAIL single_data: got %h expected %h", final_sc_fac, fill_out(7)); end
        tick();
        checks += 3;
        if (blk_cnt !== 8'd1) begin errors++; $display("FAIL single_blk: got %0d expected 1", blk_cnt); end
        if (final_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid: got %b expected 0", final_valid); end
        if (final_sc_fac !== '0) begin errors++; $display("FAIL single_idle_data: got %h expected 0", final_sc_fac); end
        $display("test_single: blk_cnt=%0d", blk_cnt);
    endtask

    task automatic test_max_sum();
        apply_reset();
        cbfp0_valid = 1; sc_fac_cbfp0 = fill_in(31);
        cbfp1_valid = 1; sc_fac_cbfp1 = fill_in(31);
        alert_cbfp2 = 1; tick();
        idle_inputs(); tick();
        checks += 2;
        if (final_valid !== 1'b1) begin errors++; $display("FAIL max_valid: got %b expected 1", final_valid); end
        if (final_sc_fac !== fill_out(62)) begin errors++; $display("FAIL max_data: got %h expected %h", final_sc_fac, fill_out(62)); end
        tick();
        $display("test_max_sum: lane0=%0d", fill_out(62) & 6'h3f);
    endtask

    task automatic test_early_alert();
        apply_reset();
        alert_cbfp2 = 1; tick();
        idle_inputs(); tick();
        cbfp0_valid = 1; sc_fac_cbfp0 = fill_in(9); tick();
        idle_inputs(); tick(); tick();
        cbfp1_valid = 1; sc_fac_cbfp1 = fill_in(5); tick();
        idle_inputs(); tick();
        checks += 3;
        if (final_valid !== 1'b1) begin errors++; $display("FAIL early_valid: got %b expected 1", final_valid); end
        if (final_sc_fac !== fill_out(14)) begin errors++; $display("FAIL early_data: got %h expected %h", final_sc_fac, fill_out(14)); end
        if (err_unf !== 1'b0) begin errors++; $display("FAIL early_unf: got %b expected 0", err_unf); end
        tick();
        // A lone alert afterwards must not produce output: pend went back to zero and FIFOs are empty.
        alert_cbfp2 = 1; tick(); idle_inputs(); tick(); tick();
        checks += 1;
        if (final_valid !== 1'b0) begin errors++; $display("FAIL early_no_extra: got %b expected 0", final_valid); end
        $display("test_early_alert: err_unf=%b", err_unf);
    endtask

    task automatic test_starve();
        apply_reset();
        alert_cbfp2 = 1; tick();
        idle_inputs();
        repeat (10) tick();
        checks += 1;
        if (err_unf !== 1'b1) begin errors++; $display("FAIL starve_unf: got %b expected 1", err_unf); end
        cbfp0_valid = 1; sc_fac_cbfp0 = fill_in(2);
        cbfp1_valid = 1; sc_fac_cbfp1 = fill_in(8); tick();
        idle_inputs(); tick();
        checks += 2;
        if (final_valid !== 1'b1) begin errors++; $display("FAIL starve_retained: got %b expected 1", final_valid); end
        if (final_sc_fac !== fill_out(10)) begin errors++; $display("FAIL starve_data: got %h expected %h", final_sc_fac, fill_out(10)); end
        tick();
        $display("test_starve: err_unf=%b", err_unf);
    endtask

    task automatic test_back_to_back();
        logic [IW-1:0] a0[3];
        logic [IW-1:0] a1[3];
        apply_reset();
        final_ready = 0;
        for (int k = 0; k < 3; k++) begin
            a0[k] = rand_vec(); a1[k] = rand_vec();
            cbfp0_valid = 1; sc_fac_cbfp0 = a0[k];
            cbfp1_valid = 1; sc_fac_cbfp1 = a1[k];
            alert_cbfp2 = 1; tick();
        end
        idle_inputs();
        for (int k = 0; k < 10; k++) begin
            tick();
            checks += 1;
            if (final_valid !== 1'b1 || final_sc_fac !== lane_sum(a0[0], a1[0])) begin
                errors++;
                $display("FAIL stall_hold: got v=%b %h expected v=1 %h", final_valid, final_sc_fac, lane_sum(a0[0], a1[0]));
            end
        end
        final_ready = 1;
        for (int k = 1; k < 3; k++) begin
            tick();
            checks += 2;
            if (final_sc_fac !== lane_sum(a0[k], a1[k]) || final_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_data%0d: got v=%b %h expected v=1 %h", k, final_valid, final_sc_fac, lane_sum(a0[k], a1[k]));
            end
            if (blk_cnt !== 8'(k)) begin errors++; $display("FAIL b2b_blk%0d: got %0d expected %0d", k, blk_cnt, k); end
        end
        tick();
        checks += 2;
        if (blk_cnt !== 8'd3) begin errors++; $display("FAIL b2b_blk_final: got %0d expected 3", blk_cnt); end
        if (final_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", final_valid); end
        $display("test_back_to_back: blk_cnt=%0d", blk_cnt);
    endtask

    task automatic test_overflow();
        int got;
        apply_reset();
        for (int k = 1; k <= 5; k++) begin
            cbfp0_valid = 1; sc_fac_cbfp0 = fill_in(k); tick();
            if (k == 4) begin
                checks += 1;
                if (err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", err_ovf); end
            end
        end
        idle_inputs();
        checks += 1;
        if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", err_ovf); end
        got = 0;
        for (int k = 0; k < 10; k++) begin
            if (k < 5) begin
                cbfp1_valid = 1; sc_fac_cbfp1 = fill_in(10); alert_cbfp2 = 1;
            end else begin
                idle_inputs();
            end
            tick();
            if (final_valid === 1'b1) begin
                got++;
                checks += 1;
                if (final_sc_fac !== fill_out(10 + got)) begin
                    errors++;
                    $display("FAIL ovf_order%0d: got %h expected %h", got, final_sc_fac, fill_out(10 + got));
                end
            end
        end
        checks += 1;
        if (got !== 4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", got); end
        $display("test_overflow: delivered=%0d", got);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        final_ready = 0;
        for (int k = 0; k < 2; k++) begin
            cbfp0_valid = 1; sc_fac_cbfp0 = rand_vec();
            cbfp1_valid = 1; sc_fac_cbfp1 = rand_vec();
            alert_cbfp2 = 1; tick();
        end
        idle_inputs();
        checks += 1;
        if (final_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", final_valid); end
        #2 rstn = 0;
        #1;
        model_reset();
        checks += 2;
        if (final_valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b expected 0", final_valid); end
        if (final_sc_fac !== '0) begin errors++; $display("FAIL mid_async_data: got %h expected 0", final_sc_fac); end
        @(posedge clk); #1;
        rstn = 1;
        final_ready = 1;
        alert_cbfp2 = 1; tick(); idle_inputs();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks += 1;
            if (final_valid !== 1'b0) begin errors++; $display("FAIL mid_flushed: got %b expected 0", final_valid); end
        end
        $display("test_reset_mid: done");
    endtask

    task automatic test_random();
        int bad = 0;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            cbfp0_valid  = ($urandom_range(0, 2) == 0);
            sc_fac_cbfp0 = rand_vec();
            cbfp1_valid  = ($urandom_range(0, 2) == 0);
            sc_fac_cbfp1 = rand_vec();
            alert_cbfp2  = ($urandom_range(0, 2) == 0);
            final_ready  = ($urandom_range(0, 3) != 0);
            tick();
            checks += 1;
            if (final_valid !== m_valid || final_sc_fac !== m_out || blk_cnt !== 8'(m_blk)
                || err_ovf !== m_ovf || err_unf !== m_unf) begin
                errors++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random_cyc%0d: got v=%b blk=%0d ovf=%b unf=%b d=%h expected v=%b blk=%0d ovf=%b unf=%b d=%h",
                             c, final_valid, blk_cnt, err_ovf, err_unf, final_sc_fac,
                             m_valid, m_blk, m_ovf, m_unf, m_out);
            end
        end
        idle_inputs();
        $display("test_random: blk_cnt=%0d", blk_cnt);
    endtask

    initial begin
        rstn = 0;
        final_ready = 1;
        idle_inputs();
        test_reset();
        test_single();
        test_max_sum();
        test_early_alert();
        test_starve();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
